// File: rtl/acc_alu_flags.sv
// acc_alu_flags: SAP datapath accumulator, B operand register, combinational
// ALU and registered zero/carry flags.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   bus              shared data bus value, sampled when a write strobe is high
//   acc_write        load acc from bus
//   acc_lower_write  load acc with {zeros, bus[7:0]} (acc_write wins)
//   b_write          load b from bus
//   alu_op           0 ADD, 1 SUB, 2 INC, 3 DEC, 4 AND, 5 OR, 6 XOR, 7 NOT
//   flag_write       capture {C, Z} of the current ALU result
//   alu_out          combinational ALU result
//   acc_out, b_out   registered accumulator / B values
//   flag             registered flags, flag[0] = Z, flag[1] = C
//   WIDTH            datapath width, must be at least 9
module acc_alu_flags #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus,
    input  logic             acc_write,
    input  logic             acc_lower_write,
    input  logic             b_write,
    input  logic [3:0]       alu_op,
    input  logic             flag_write,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] b_out,
    output logic [1:0]       flag
);

    localparam int unsigned EXT_W  = WIDTH + 1;
    localparam int unsigned HIGH_W = WIDTH - 8;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_INC = 4'd2;
    localparam logic [3:0] OP_DEC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] b;
    logic [EXT_W-1:0] ext_a;
    logic [EXT_W-1:0] ext_b;
    logic [EXT_W-1:0] ext_res;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;

    assign ext_a = {1'b0, acc};
    assign ext_b = {1'b0, b};

    // ALU: arithmetic done one bit wider so the top bit is carry (ADD/INC)
    // or borrow (SUB/DEC, wraps to 1 exactly when the operand is smaller).
    always_comb begin
        ext_res = '0;
        result  = '0;
        carry   = 1'b0;
        unique case (alu_op)
            OP_ADD: begin
                ext_res = ext_a + ext_b;
                result  = ext_res[WIDTH-1:0];
                carry   = ext_res[WIDTH];
            end
            OP_SUB: begin
                ext_res = ext_a - ext_b;
                result  = ext_res[WIDTH-1:0];
                carry   = ext_res[WIDTH];
            end
            OP_INC: begin
                ext_res = ext_a + EXT_W'(1);
                result  = ext_res[WIDTH-1:0];
                carry   = ext_res[WIDTH];
            end
            OP_DEC: begin
                ext_res = ext_a - EXT_W'(1);
                result  = ext_res[WIDTH-1:0];
                carry   = ext_res[WIDTH];
            end
            OP_AND:  result = acc & b;
            OP_OR:   result = acc | b;
            OP_XOR:  result = acc ^ b;
            OP_NOT:  result = ~acc;
            default: result = '0;
        endcase
    end

    assign zero    = (result == '0);
    assign alu_out = result;

    // Accumulator: full load beats lower-byte load; reset beats both.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (acc_write) begin
            acc <= bus;
        end else if (acc_lower_write) begin
            acc <= {{HIGH_W{1'b0}}, bus[7:0]};
        end
    end

    // B operand register
    always_ff @(posedge clk) begin
        if (rst) begin
            b <= '0;
        end else if (b_write) begin
            b <= bus;
        end
    end

    // Flags sample the ALU on pre-edge acc/b, so a coincident acc_write of
    // alu_out leaves flags describing the value just written.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag <= 2'b00;
        end else if (flag_write) begin
            flag <= {carry, zero};
        end
    end

    assign acc_out = acc;
    assign b_out   = b;

endmodule

// File: tb/tb_acc_alu_flags.sv
// Directed self-checking bench for acc_alu_flags with hand-computed vectors.
module tb_acc_alu_flags;

    logic        clk;
    logic        rst;
    logic [15:0] bus;
    logic [15:0] bus_val;
    logic        alu_to_bus;
    logic        acc_write;
    logic        acc_lower_write;
    logic        b_write;
    logic [3:0]  alu_op;
    logic        flag_write;
    logic [15:0] alu_out;
    logic [15:0] acc_out;
    logic [15:0] b_out;
    logic [1:0]  flag;

    int checks;
    int errors;

    // bus mirrors the datapath mux: ALU result or a literal value
    assign bus = alu_to_bus ? alu_out : bus_val;

    acc_alu_flags #(.WIDTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .acc_write       (acc_write),
        .acc_lower_write (acc_lower_write),
        .b_write         (b_write),
        .alu_op          (alu_op),
        .flag_write      (flag_write),
        .alu_out         (alu_out),
        .acc_out         (acc_out),
        .b_out           (b_out),
        .flag            (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        acc_write       = 1'b0;
        acc_lower_write = 1'b0;
        b_write         = 1'b0;
        flag_write      = 1'b0;
        alu_to_bus      = 1'b0;
        rst             = 1'b0;
    endtask

    task automatic load_acc(input logic [15:0] v);
        bus_val   = v;
        acc_write = 1'b1;
        tick();
        acc_write = 1'b0;
    endtask

    task automatic load_b(input logic [15:0] v);
        bus_val = v;
        b_write = 1'b1;
        tick();
        b_write = 1'b0;
    endtask

    // ALU cycle writing the result back into acc and capturing flags
    task automatic alu_wb(input logic [3:0] op);
        alu_op     = op;
        alu_to_bus = 1'b1;
        acc_write  = 1'b1;
        flag_write = 1'b1;
        tick();
        clear_strobes();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        bus_val = 16'h0000;
        alu_op  = 4'd0;
        clear_strobes();
        @(negedge clk);

        // Reset overrides every strobe
        rst             = 1'b1;
        bus_val         = 16'hFFFF;
        acc_write       = 1'b1;
        acc_lower_write = 1'b1;
        b_write         = 1'b1;
        flag_write      = 1'b1;
        alu_op          = 4'd7;
        tick();
        clear_strobes();
        check("reset_acc", acc_out, 16'h0000);
        check("reset_b", b_out, 16'h0000);
        check("reset_flag", 16'(flag), 16'h0000);
        check("reset_alu_not", alu_out, 16'hFFFF);
        alu_op = 4'd0;
        #1;
        check("reset_alu_add", alu_out, 16'h0000);

        // ADD overflow
        load_acc(16'hFFFF);
        load_b(16'h0001);
        check("load_acc", acc_out, 16'hFFFF);
        check("load_b", b_out, 16'h0001);
        check("flag_untouched_by_loads", 16'(flag), 16'h0000);
        alu_wb(4'd0);
        check("add_ovf_acc", acc_out, 16'h0000);
        check("add_ovf_flag", 16'(flag), 16'h0003);

        // SUB borrow, then SUB to zero
        load_acc(16'h0003);
        load_b(16'h0005);
        alu_op = 4'd1;
        #1;
        check("sub_alu_comb", alu_out, 16'hFFFE);
        alu_wb(4'd1);
        check("sub_borrow_acc", acc_out, 16'hFFFE);
        check("sub_borrow_flag", 16'(flag), 16'h0002);
        load_b(16'h0003);
        load_acc(16'h0003);
        alu_wb(4'd1);
        check("sub_zero_acc", acc_out, 16'h0000);
        check("sub_zero_flag", 16'(flag), 16'h0001);

        // DEC from zero, INC from all-ones (back-to-back)
        alu_wb(4'd3);
        check("dec_wrap_acc", acc_out, 16'hFFFF);
        check("dec_wrap_flag", 16'(flag), 16'h0002);
        alu_wb(4'd2);
        check("inc_wrap_acc", acc_out, 16'h0000);
        check("inc_wrap_flag", 16'(flag), 16'h0003);

        // Lower-byte load and priority; flags stay at 11
        load_acc(16'hABCD);
        bus_val         = 16'h1234;
        acc_lower_write = 1'b1;
        tick();
        clear_strobes();
        check("ldi_acc", acc_out, 16'h0034);
        check("ldi_flag", 16'(flag), 16'h0003);
        bus_val         = 16'h5678;
        acc_write       = 1'b1;
        acc_lower_write = 1'b1;
        tick();
        clear_strobes();
        check("ldi_prio_acc", acc_out, 16'h5678);
        check("ldi_prio_flag", 16'(flag), 16'h0003);

        // Logic ops
        load_acc(16'hF0F0);
        load_b(16'h0FF0);
        alu_op = 4'd5;
        #1;
        check("or_comb", alu_out, 16'hFFF0);
        alu_op     = 4'd4;
        flag_write = 1'b1;
        #1;
        check("and_comb", alu_out, 16'h00F0);
        tick();
        clear_strobes();
        check("and_flag", 16'(flag), 16'h0000);
        check("and_acc_hold", acc_out, 16'hF0F0);
        alu_wb(4'd6);
        check("xor_acc", acc_out, 16'hFF00);
        alu_wb(4'd7);
        check("not_acc", acc_out, 16'h00FF);
        check("not_flag", 16'(flag), 16'h0000);

        // SUB would borrow, but flag_write is low: flags hold
        alu_op = 4'd1;
        #1;
        check("sub_nowrite_comb", alu_out, 16'hF10F);
        tick();
        check("flag_hold", 16'(flag), 16'h0000);

        // Reserved op gives zero result, Z=1 C=0
        alu_op     = 4'd12;
        flag_write = 1'b1;
        #1;
        check("reserved_comb", alu_out, 16'h0000);
        tick();
        clear_strobes();
        check("reserved_flag", 16'(flag), 16'h0001);

        // b_write alone leaves flags
        load_b(16'h0000);
        check("b_zero", b_out, 16'h0000);
        check("flag_after_bwrite", 16'(flag), 16'h0001);

        // Reset mid-operation discards the pending write
        alu_op = 4'd2;
        alu_wb(4'd2);
        check("inc_before_rst", acc_out, 16'h0100);
        rst        = 1'b1;
        alu_to_bus = 1'b1;
        acc_write  = 1'b1;
        flag_write = 1'b1;
        tick();
        clear_strobes();
        check("rst2_acc", acc_out, 16'h0000);
        check("rst2_flag", 16'(flag), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_alu_flags.md
# acc_alu_flags

Accumulator, B operand register, 16-bit ALU and zero/carry flag register for the SAP datapath. It sits directly downstream of the control unit and consumes its `acc_write`, `acc_lower_write`, `alu_op`, `b_write` and `flag_write` strobes. It drives `alu_out` and `acc_out` toward the bus mux, and returns the registered `flag[1:0]` to the control unit for JMPZ/JMPC decisions.

## Interface
- `WIDTH`, 16, datapath/bus width; must be ≥ 9.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `bus`  in  WIDTH  shared data bus value, valid in the cycle a write strobe is high.
- `acc_write`  in  1  load `acc` from `bus`.
- `acc_lower_write`  in  1  load `acc[7:0]` from `bus[7:0]`, zero `acc[WIDTH-1:8]`.
- `b_write`  in  1  load `b` from `bus`.
- `alu_op`  in  4  0 ADD, 1 SUB, 2 INC, 3 DEC, 4 AND, 5 OR, 6 XOR, 7 NOT, 8–15 reserved.
- `flag_write`  in  1  capture Z/C of the current ALU result.
- `alu_out`  out  WIDTH  combinational ALU result, fed to the bus mux when `alu_to_bus` is high.
- `acc_out`  out  WIDTH  registered accumulator value, fed to the bus mux when `acc_to_bus` is high.
- `b_out`  out  WIDTH  registered B value (debug/observability).
- `flag`  out  2  registered flags: `flag[0]` = Z, `flag[1]` = C.

## Operation
- **ALU.** Purely combinational from the current `acc` (A), `b` (B) and `alu_op`. It produces result R and carry c.
  - ADD: R = A+B mod 2^W; c = carry out of bit W-1.
  - SUB: R = A−B mod 2^W; c = 1 iff A < B (unsigned borrow).
  - INC: R = A+1; c = 1 iff A = all-ones.
  - DEC: R = A−1; c = 1 iff A = 0 (borrow).
  - AND / OR / XOR: bitwise A op B; c = 0.
  - NOT: R = ~A; c = 0.
  - Reserved ops 8–15: R = 0; c = 0.
  - Z = (R == 0), computed on the full WIDTH result.
- **Accumulator write priority.**
  - `acc_write` loads `acc` with `bus`.
  - Else `acc_lower_write` loads `acc` with {zeros, `bus[7:0]`}.
  - Else `acc` holds.
  - If both strobes are high, `acc_write` wins.
- **B register.** `b_write` loads `b` with `bus`; otherwise `b` holds.
- **Flags.** `flag_write` registers {c, Z} from the ALU output in that same cycle, i.e. computed from pre-edge `acc`/`b`. Otherwise `flag` holds. Flags are never changed by `acc_write`, `acc_lower_write` or `b_write` alone.
- **Same-cycle updates.** When `acc_write` and `flag_write` coincide (the control unit's alu3, INC/DEC/NOT cycles), the flags describe the value being written, because `bus` = `alu_out` in those cycles.
- **No internal bus drivers.** The block contains no tri-states and no bus mux.

## Timing
- **Reset.** `rst` high at a rising edge sets `acc` = 0, `b` = 0, `flag` = 2'b00. Therefore `acc_out` = 0, `b_out` = 0, `flag` = 0, and `alu_out` = ALU(0, 0, `alu_op`).
- **Reset priority.** Reset overrides every strobe in the same cycle. Reset mid-instruction discards pending data; there is no partial update.
- **Write latency.** 1 cycle: a strobe high in cycle n makes the new value visible on `acc_out`/`b_out`/`flag` in cycle n+1.
- **`alu_out` latency.** 0 cycles from `acc`/`b`/`alu_op`; it reflects new `acc`/`b` from cycle n+1.
- **Back-to-back writes.** Strobes in consecutive cycles each take effect; there is no hold-off.
- **Wrap-around.** All arithmetic is modulo 2^WIDTH; carry/borrow is exposed only through C.

## Test plan
- **Reset:** assert `rst` with all strobes high and `bus` = 16'hFFFF → next cycle `acc` = 0, `b` = 0, `flag` = 00.
- **ADD overflow:**
  - Load `acc` = 16'hFFFF, `b` = 16'h0001.
  - Issue `alu_op` = 0 with `acc_write` + `flag_write`, driving `bus` = `alu_out`.
  - Expect `acc` = 16'h0000, `flag` = 2'b11.
- **SUB borrow:**
  - `acc` = 16'h0003, `b` = 16'h0005, SUB → `acc` = 16'hFFFE, `flag` = 2'b10.
  - Then `b` = 16'h0003, `acc` = 16'h0003, SUB → `acc` = 0, `flag` = 2'b01.
- **INC/DEC edges:**
  - `acc` = 16'h0000, DEC → 16'hFFFF, `flag` = 2'b10.
  - Then INC → 16'h0000, `flag` = 2'b11.
- **LDI priority:**
  - `acc` = 16'hABCD; `acc_lower_write` with `bus` = 16'h1234 → `acc` = 16'h0034.
  - `acc_write` + `acc_lower_write` with `bus` = 16'h5678 → `acc` = 16'h5678.
  - Flags unchanged in both steps.
- **Logic ops and flag hold:**
  - `acc` = 16'hF0F0, `b` = 16'h0FF0.
  - AND → 16'h00F0, `flag` = 00.
  - XOR → 16'hFF00.
  - NOT → 16'h00FF.
  - Then an ALU cycle with `flag_write` = 0 → `flag` retains its prior value.
  - Reserved op 12 with `flag_write` → `flag` = 2'b01.
